// File: rtl/sim_phase_sequencer.sv
// sim_phase_sequencer: one FSM for the whole simulation timeline.
// It first walks the nest, sugar patch and ant setup items over a req/ack
// handshake with the initializer. It then raster-sweeps the grid to drive
// environment and ant updates. Between sweeps it can pause, single-step or
// wait for a programmable number of cycles.
module sim_phase_sequencer #(
  parameter int X_bits         = 8,
  parameter int Y_bits         = 8,
  parameter int X_MAX          = 159,
  parameter int Y_MAX          = 119,
  parameter int NEST_num       = 2,
  parameter int SUGARPATCH_num = 4,
  parameter int ANT_num        = 16,
  parameter int SLOW_bits      = 23,
  localparam int NEST_W  = (NEST_num > 1) ? $clog2(NEST_num) : 1,
  localparam int PATCH_W = (SUGARPATCH_num > 1) ? $clog2(SUGARPATCH_num) : 1,
  localparam int ANT_W   = (ANT_num > 1) ? $clog2(ANT_num) : 1
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_SIM_N,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 step,
  input  logic [SLOW_bits-1:0] speed_factor,
  input  logic                 setup_ack,
  output logic                 SETUP_MODE,
  output logic                 setup_req,
  output logic [NEST_W-1:0]    nest_id,
  output logic [PATCH_W-1:0]   patch_id,
  output logic [ANT_W-1:0]     ant_id,
  output logic [X_bits-1:0]    writeLoc_x,
  output logic [Y_bits-1:0]    writeLoc_y,
  output logic [X_bits-1:0]    viewLoc_x,
  output logic [Y_bits-1:0]    viewLoc_y,
  output logic                 write_flag,
  output logic                 sweep_done,
  output logic [15:0]          generation,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SETUP_NEST  = 3'd1,
    S_SETUP_PATCH = 3'd2,
    S_SETUP_ANT   = 3'd3,
    S_RUN_SWEEP   = 3'd4,
    S_RUN_WAIT    = 3'd5,
    S_PAUSED      = 3'd6
  } state_e;

  localparam logic [NEST_W-1:0]  NEST_LAST  = NEST_W'(NEST_num - 1);
  localparam logic [PATCH_W-1:0] PATCH_LAST = PATCH_W'(SUGARPATCH_num - 1);
  localparam logic [ANT_W-1:0]   ANT_LAST   = ANT_W'(ANT_num - 1);
  localparam logic [X_bits-1:0]  X_LAST     = X_bits'(X_MAX);
  localparam logic [Y_bits-1:0]  Y_LAST     = Y_bits'(Y_MAX);

  state_e               state_q, state_d;
  logic [NEST_W-1:0]    nest_q, nest_d;
  logic [PATCH_W-1:0]   patch_q, patch_d;
  logic [ANT_W-1:0]     ant_q, ant_d;
  logic [X_bits-1:0]    x_q, x_d;
  logic [Y_bits-1:0]    y_q, y_d;
  logic [15:0]          gen_q, gen_d;
  logic [SLOW_bits-1:0] wait_q, wait_d;
  logic                 step_sweep_q, step_sweep_d;

  logic [X_bits-1:0]    succ_x;
  logic [Y_bits-1:0]    succ_y;
  logic                 last_loc;

  // Raster successor of the write location; it doubles as the view lookahead.
  always_comb begin
    last_loc = (x_q == X_LAST) && (y_q == Y_LAST);
    if (x_q == X_LAST) begin
      succ_x = '0;
      succ_y = (y_q == Y_LAST) ? '0 : y_q + Y_bits'(1);
    end else begin
      succ_x = x_q + X_bits'(1);
      succ_y = y_q;
    end
  end

  // Next-state logic for the phase FSM, the setup ids, the raster and the counters.
  always_comb begin
    // NOTE: every *_d gets its hold value first, so paths that leave a
    // signal unassigned keep the register value instead of inferring a latch.
    state_d      = state_q;
    nest_d       = nest_q;
    patch_d      = patch_q;
    ant_d        = ant_q;
    x_d          = x_q;
    y_d          = y_q;
    gen_d        = gen_q;
    wait_d       = wait_q;
    step_sweep_d = step_sweep_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETUP_NEST;
      end
      S_SETUP_NEST: begin
        if (setup_ack) begin
          if (nest_q == NEST_LAST) begin
            nest_d  = '0;
            state_d = S_SETUP_PATCH;
          end else begin
            nest_d = nest_q + NEST_W'(1);
          end
        end
      end
      S_SETUP_PATCH: begin
        if (setup_ack) begin
          if (patch_q == PATCH_LAST) begin
            patch_d = '0;
            state_d = S_SETUP_ANT;
          end else begin
            patch_d = patch_q + PATCH_W'(1);
          end
        end
      end
      S_SETUP_ANT: begin
        if (setup_ack) begin
          if (ant_q == ANT_LAST) begin
            ant_d   = '0;
            state_d = S_RUN_SWEEP;
          end else begin
            ant_d = ant_q + ANT_W'(1);
          end
        end
      end
      S_RUN_SWEEP: begin
        x_d = succ_x;
        y_d = succ_y;
        if (last_loc) begin
          gen_d        = gen_q + 16'd1;
          step_sweep_d = 1'b0;
          wait_d       = speed_factor;
          // A step sweep always parks in PAUSED, whatever pause is doing.
          if (pause || step_sweep_q)  state_d = S_PAUSED;
          else if (speed_factor == '0) state_d = S_RUN_SWEEP;
          else                         state_d = S_RUN_WAIT;
        end
      end
      S_RUN_WAIT: begin
        // A count of N gives exactly N idle cycles; 0 gives one cycle on the way out of PAUSED.
        if (pause)                           state_d = S_PAUSED;
        else if (wait_q <= SLOW_bits'(1))    state_d = S_RUN_SWEEP;
        else                                 wait_d  = wait_q - SLOW_bits'(1);
      end
      S_PAUSED: begin
        if (step) begin
          step_sweep_d = 1'b1;
          state_d      = S_RUN_SWEEP;
        end else if (!pause) begin
          wait_d  = '0;
          state_d = S_RUN_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLOCK_50 or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      state_q      <= S_IDLE;
      nest_q       <= '0;
      patch_q      <= '0;
      ant_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      gen_q        <= '0;
      wait_q       <= '0;
      step_sweep_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q      <= state_d;
      nest_q       <= nest_d;
      patch_q      <= patch_d;
      ant_q        <= ant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gen_q        <= gen_d;
      wait_q       <= wait_d;
      step_sweep_q <= step_sweep_d;
    end
  end

  // Outputs decode straight from registers, so reset reaches them without an edge.
  assign setup_req  = (state_q == S_SETUP_NEST) || (state_q == S_SETUP_PATCH) ||
                      (state_q == S_SETUP_ANT);
  assign SETUP_MODE = setup_req || (state_q == S_IDLE);
  assign write_flag = (state_q == S_RUN_SWEEP);
  assign sweep_done = write_flag && last_loc;
  assign nest_id    = nest_q;
  assign patch_id   = patch_q;
  assign ant_id     = ant_q;
  assign writeLoc_x = x_q;
  assign writeLoc_y = y_q;
  assign viewLoc_x  = succ_x;
  assign viewLoc_y  = succ_y;
  assign generation = gen_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sim_phase_sequencer.sv
// Scoreboard bench for sim_phase_sequencer: the stimulus process queues the
// expected setup handshakes and sweep-end reports, and a monitor pops and
// compares them whenever the DUT shows a handshake or a sweep_done pulse.
module tb_sim_phase_sequencer;

  localparam int XM = 159;
  localparam int YM = 119;
  localparam int CELLS = (XM + 1) * (YM + 1);

  logic        CLOCK_50;
  logic        RESET_SIM_N;
  logic        start, pause, step, setup_ack;
  logic [22:0] speed_factor;
  logic        SETUP_MODE, setup_req, write_flag, sweep_done;
  logic [0:0]  nest_id;
  logic [1:0]  patch_id;
  logic [3:0]  ant_id;
  logic [7:0]  writeLoc_x, writeLoc_y, viewLoc_x, viewLoc_y;
  logic [15:0] generation;
  logic [2:0]  state_o;

  typedef struct {
    int kind;  // 0: setup handshake, 1: sweep end
    int a;     // setup: state / sweep: x
    int b;     // setup: id    / sweep: y
    int c;     // sweep: generation before increment
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  sim_phase_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_SIM_N (RESET_SIM_N),
    .start       (start),
    .pause       (pause),
    .step        (step),
    .speed_factor(speed_factor),
    .setup_ack   (setup_ack),
    .SETUP_MODE  (SETUP_MODE),
    .setup_req   (setup_req),
    .nest_id     (nest_id),
    .patch_id    (patch_id),
    .ant_id      (ant_id),
    .writeLoc_x  (writeLoc_x),
    .writeLoc_y  (writeLoc_y),
    .viewLoc_x   (viewLoc_x),
    .viewLoc_y   (viewLoc_y),
    .write_flag  (write_flag),
    .sweep_done  (sweep_done),
    .generation  (generation),
    .state_o     (state_o)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per setup handshake or sweep_done pulse.
  initial begin : monitor
    exp_t e;
    int   cur_id;
    forever begin
      @(negedge CLOCK_50);
      if (RESET_SIM_N && ((setup_req && setup_ack) || sweep_done)) begin
        check("sb_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (sweep_done) begin
            check("sb_kind_sweep", e.kind, 1);
            check("done_x", int'(writeLoc_x), e.a);
            check("done_y", int'(writeLoc_y), e.b);
            check("done_gen", int'(generation), e.c);
          end else begin
            case (state_o)
              3'd1:    cur_id = int'(nest_id);
              3'd2:    cur_id = int'(patch_id);
              3'd3:    cur_id = int'(ant_id);
              default: cur_id = -1;
            endcase
            check("sb_kind_setup", e.kind, 0);
            check("setup_state", int'(state_o), e.a);
            check("setup_id", cur_id, e.b);
          end
        end
      end
    end
  end

  // One full sweep, sampled at every negedge against a raster model.
  // pause is raised / dropped at the given cycle index (-1 = never).
  task automatic do_sweep(input int gen_exp, input int pause_hi_at, input int pause_lo_at);
    int ex, ey, vx, vy;
    int bad_wf, bad_loc, bad_view, done_cnt;
    exp_t e;
    e.kind = 1; e.a = XM; e.b = YM; e.c = gen_exp;
    sb.push_back(e);
    ex = 0; ey = 0; bad_wf = 0; bad_loc = 0; bad_view = 0; done_cnt = 0;
    for (int c = 0; c < CELLS; c++) begin
      @(negedge CLOCK_50);
      if (c == pause_hi_at) pause = 1'b1;
      if (c == pause_lo_at) pause = 1'b0;
      vx = (ex == XM) ? 0 : ex + 1;
      vy = (ex == XM) ? ((ey == YM) ? 0 : ey + 1) : ey;
      if (!write_flag) bad_wf++;
      if (int'(writeLoc_x) != ex || int'(writeLoc_y) != ey) bad_loc++;
      if (int'(viewLoc_x) != vx || int'(viewLoc_y) != vy) bad_view++;
      if (sweep_done) done_cnt++;
      if (ex == XM && ey == 0) begin
        check("view_row_wrap", int'(viewLoc_x) * 256 + int'(viewLoc_y), 0 * 256 + 1);
      end
      if (ex == XM && ey == YM) begin
        check("view_grid_wrap", int'(viewLoc_x) * 256 + int'(viewLoc_y), 0);
        check("done_on_last", int'(sweep_done), 1);
      end
      ex = vx; ey = vy;
    end
    check("sweep_write_flag_gaps", bad_wf, 0);
    check("sweep_loc_errors", bad_loc, 0);
    check("sweep_view_errors", bad_view, 0);
    check("sweep_done_count", done_cnt, 1);
  endtask

  initial begin : stim
    exp_t e;
    int   exp_id, gap, n;
    RESET_SIM_N  = 1'b0;
    start        = 1'b0;
    pause        = 1'b0;
    step         = 1'b0;
    setup_ack    = 1'b0;
    speed_factor = '0;

    // Reset values, observed while reset is held.
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_state", int'(state_o), 0);
    check("rst_ids", int'(nest_id) + int'(patch_id) + int'(ant_id), 0);
    check("rst_write_xy", int'(writeLoc_x) * 256 + int'(writeLoc_y), 0);
    check("rst_view_xy", int'(viewLoc_x) * 256 + int'(viewLoc_y), 1 * 256 + 0);
    check("rst_flags", int'({write_flag, setup_req, sweep_done}), 0);
    check("rst_gen", int'(generation), 0);
    check("rst_setup_mode", int'(SETUP_MODE), 1);
    RESET_SIM_N = 1'b1;

    // setup_ack outside the setup states does nothing.
    setup_ack = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("idle_ack_ignored", int'(state_o), 0);
    check("idle_no_req", int'(setup_req), 0);
    setup_ack = 1'b0;

    // Queue all 22 expected setup handshakes, then start.
    for (int i = 0; i < 22; i++) begin
      e.kind = 0;
      e.a = (i < 2) ? 1 : (i < 6) ? 2 : 3;
      e.b = (i < 2) ? i : (i < 6) ? i - 2 : i - 6;
      e.c = 0;
      sb.push_back(e);
    end
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("start_to_setup_nest", int'(state_o), 1);

    // Ack every second cycle; the id must already be stable in the idle cycle.
    for (int i = 0; i < 22; i++) begin
      exp_id = (i < 2) ? i : (i < 6) ? i - 2 : i - 6;
      @(negedge CLOCK_50);
      check("setup_req_held", int'(setup_req), 1);
      case (state_o)
        3'd1:    check("nest_id_stable", int'(nest_id), exp_id);
        3'd2:    check("patch_id_stable", int'(patch_id), exp_id);
        default: check("ant_id_stable", int'(ant_id), exp_id);
      endcase
      @(posedge CLOCK_50);
      #1 setup_ack = 1'b1;
      @(posedge CLOCK_50);
      #1 setup_ack = 1'b0;
    end
    check("run_state", int'(state_o), 4);
    check("run_setup_mode", int'(SETUP_MODE), 0);
    check("run_req_dropped", int'(setup_req), 0);
    check("run_ids_zero", int'(nest_id) + int'(patch_id) + int'(ant_id), 0);

    // Sweep A at speed 0: back-to-back with the next one.
    do_sweep(0, -1, -1);
    @(posedge CLOCK_50);
    #1;
    check("gen_after_a", int'(generation), 1);
    check("no_gap_state", int'(state_o), 4);
    check("no_gap_write_flag", int'(write_flag), 1);
    check("wrap_write_xy", int'(writeLoc_x) * 256 + int'(writeLoc_y), 0);

    // Sweep B, speed 5 sampled at its end: exactly 5 idle cycles follow.
    speed_factor = 23'd5;
    do_sweep(1, -1, -1);
    @(posedge CLOCK_50);
    #1;
    check("gen_after_b", int'(generation), 2);
    check("wait_state", int'(state_o), 5);
    check("wait_loc_hold", int'(writeLoc_x) * 256 + int'(writeLoc_y), 0);
    gap = 0;
    while (!write_flag && gap < 100) begin
      gap++;
      @(posedge CLOCK_50);
      #1;
    end
    check("gap_cycles", gap, 5);

    // Sweep C with pause raised mid-sweep: it completes, then PAUSED.
    do_sweep(2, 100, -1);
    @(posedge CLOCK_50);
    #1;
    check("paused_state", int'(state_o), 6);
    check("gen_after_c", int'(generation), 3);
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("paused_hold", int'(state_o), 6);
    check("paused_no_write", int'(write_flag), 0);

    // Step: one sweep, pause released during it, still back to PAUSED.
    step = 1'b1;
    @(posedge CLOCK_50);
    #1 step = 1'b0;
    check("step_to_sweep", int'(state_o), 4);
    do_sweep(3, -1, 50);
    @(posedge CLOCK_50);
    #1;
    check("step_back_paused", int'(state_o), 6);
    check("gen_after_step", int'(generation), 4);
    @(posedge CLOCK_50);
    #1;
    check("release_to_wait", int'(state_o), 5);
    @(posedge CLOCK_50);
    #1;
    check("release_to_sweep", int'(state_o), 4);

    // Reset mid-sweep at (80,60): takes effect before the next edge.
    n = 0;
    while (!(writeLoc_x == 8'd80 && writeLoc_y == 8'd60) && n < 20000) begin
      @(posedge CLOCK_50);
      #1;
      n++;
    end
    check("reached_80_60", int'(writeLoc_x) * 256 + int'(writeLoc_y), 80 * 256 + 60);
    #2 RESET_SIM_N = 1'b0;
    #1;
    check("async_rst_state", int'(state_o), 0);
    check("async_rst_write_xy", int'(writeLoc_x) * 256 + int'(writeLoc_y), 0);
    check("async_rst_gen", int'(generation), 0);
    check("async_rst_write_flag", int'(write_flag), 0);
    check("async_rst_setup_mode", int'(SETUP_MODE), 1);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
